// File: rtl/multi_timer.sv
// multi_timer: NUM_CH down-counters stepped by a shared prescaler tick, behind an 8-bit bus register window.
// Build option TIMER_SNAPSHOT_EN: a LO read latches the COUNT high bits so that the following HI read is atomic.
module multi_timer #(
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned PRESCALE  = 100000,
    parameter logic [7:0]  BASE_ADDR = 8'hF0
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic [7:0] BUS_ADDR,
    inout  logic [7:0] BUS_DATA,
    input  logic       BUS_WE,
    output logic       BUS_INTERRUPT_RAISE,
    input  logic       BUS_INTERRUPT_ACK
);

    localparam int unsigned PS_W = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam int unsigned HI_W = CNT_W - 8;

    logic [PS_W-1:0]   presc_q, presc_d;
    logic              tick_c;

    logic [NUM_CH-1:0] en_q, en_d, per_q, per_d, ie_q, ie_d, pend_q, pend_d;
    logic [CNT_W-1:0]  reload_q [NUM_CH];
    logic [CNT_W-1:0]  reload_d [NUM_CH];
    logic [CNT_W-1:0]  count_q  [NUM_CH];
    logic [CNT_W-1:0]  count_d  [NUM_CH];
`ifdef TIMER_SNAPSHOT_EN
    logic [HI_W-1:0]   shadow_q [NUM_CH];
    logic [HI_W-1:0]   shadow_d [NUM_CH];
`endif

    logic              rd_vld_q, rd_vld_d;
    logic [7:0]        rd_data_q, rd_data_d;

    logic              hit_c, wr_c, rd_c;
    logic [1:0]        sel_ch_c, sel_reg_c;
    logic [NUM_CH-1:0] irq_c, ack_clr_c, expire_c;

    // Window decode: 16-aligned base, channels beyond NUM_CH are holes
    assign sel_ch_c  = BUS_ADDR[3:2];
    assign sel_reg_c = BUS_ADDR[1:0];
    assign hit_c     = (BUS_ADDR[7:4] == BASE_ADDR[7:4]) && (32'(sel_ch_c) < NUM_CH);
    assign wr_c      = hit_c && BUS_WE;
    assign rd_c      = hit_c && !BUS_WE;

    assign tick_c  = (presc_q == PS_W'(PRESCALE - 1));
    assign presc_d = tick_c ? '0 : presc_q + PS_W'(1);

    // Lowest-index enabled pending channel is the one an ACK clears
    assign irq_c               = pend_q & ie_q;
    assign ack_clr_c           = irq_c & (~irq_c + NUM_CH'(1));
    assign BUS_INTERRUPT_RAISE = |irq_c;

    always_comb begin
        expire_c = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            expire_c[c] = tick_c && en_q[c] && (count_q[c] == '0);
        end
    end

    // Channel update; later assignments win: tick < ACK/write < expiry set
    always_comb begin
        en_d     = en_q;
        per_d    = per_q;
        ie_d     = ie_q;
        pend_d   = pend_q;
        reload_d = reload_q;
        count_d  = count_q;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (tick_c && en_q[c]) begin
                if (count_q[c] != '0) begin
                    count_d[c] = count_q[c] - CNT_W'(1);
                end else if (per_q[c]) begin
                    count_d[c] = reload_q[c];
                end else begin
                    en_d[c] = 1'b0;
                end
            end
            if (BUS_INTERRUPT_ACK && ack_clr_c[c]) begin
                pend_d[c] = 1'b0;
            end
            if (wr_c && (sel_ch_c == 2'(c))) begin
                case (sel_reg_c)
                    2'd0: begin
                        en_d[c]  = BUS_DATA[0];
                        per_d[c] = BUS_DATA[1];
                        ie_d[c]  = BUS_DATA[2];
                        if ((BUS_DATA[0] && !en_q[c]) || BUS_DATA[3]) begin
                            count_d[c] = reload_q[c];
                        end
                        if (BUS_DATA[7]) begin
                            pend_d[c] = 1'b0;
                        end
                    end
                    2'd1:    reload_d[c][7:0]       = BUS_DATA;
                    2'd2:    reload_d[c][CNT_W-1:8] = BUS_DATA[HI_W-1:0];
                    default: ;
                endcase
            end
            if (expire_c[c]) begin
                pend_d[c] = 1'b1;
            end
        end
    end

    // Read path: data captured with the address, driven for one cycle after
    always_comb begin
        rd_vld_d  = rd_c;
        rd_data_d = '0;
`ifdef TIMER_SNAPSHOT_EN
        shadow_d  = shadow_q;
`endif
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (rd_c && (sel_ch_c == 2'(c))) begin
                case (sel_reg_c)
                    2'd0: rd_data_d = {pend_q[c], 4'b0000, ie_q[c], per_q[c], en_q[c]};
                    2'd1: begin
                        rd_data_d = count_q[c][7:0];
`ifdef TIMER_SNAPSHOT_EN
                        shadow_d[c] = count_q[c][CNT_W-1:8];
`endif
                    end
`ifdef TIMER_SNAPSHOT_EN
                    2'd2:    rd_data_d = 8'(shadow_q[c]);
`else
                    2'd2:    rd_data_d = 8'(count_q[c][CNT_W-1:8]);
`endif
                    default: rd_data_d = '0;
                endcase
            end
        end
    end

    assign BUS_DATA = rd_vld_q ? rd_data_q : 8'hzz;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            presc_q   <= '0;
            en_q      <= '0;
            per_q     <= '0;
            ie_q      <= '0;
            pend_q    <= '0;
            reload_q  <= '{default: '0};
            count_q   <= '{default: '0};
            rd_vld_q  <= 1'b0;
            rd_data_q <= '0;
`ifdef TIMER_SNAPSHOT_EN
            shadow_q  <= '{default: '0};
`endif
        end else begin
            presc_q   <= presc_d;
            en_q      <= en_d;
            per_q     <= per_d;
            ie_q      <= ie_d;
            pend_q    <= pend_d;
            reload_q  <= reload_d;
            count_q   <= count_d;
            rd_vld_q  <= rd_vld_d;
            rd_data_q <= rd_data_d;
`ifdef TIMER_SNAPSHOT_EN
            shadow_q  <= shadow_d;
`endif
        end
    end

endmodule

// File: tb/tb_multi_timer.sv
// Self-checking bench for multi_timer: register vector table plus timed sequences for ticks, IRQ priority and collisions.
module tb_multi_timer;

    localparam int unsigned NCH = 3;
    localparam int unsigned CW  = 12;
    localparam int unsigned PS  = 4;
    localparam int unsigned NV  = 19;

    typedef struct {
        logic [7:0] addr;
        logic       we;
        logic [7:0] data;   // write data, or expected read data
    } vec_t;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] addr  = 8'h00;
    logic [7:0] wdata = 8'h00;
    logic       we    = 1'b0;
    logic       oe    = 1'b0;
    logic       ack   = 1'b0;
    logic       raise;
    wire  [7:0] bus_data;

    int unsigned cyc;
    int          n_vec = 0;
    int          n_err = 0;
    logic [7:0]  sb_q [$];
    vec_t        vecs [NV];

    assign bus_data = oe ? wdata : 8'hzz;

    multi_timer #(
        .NUM_CH   (NCH),
        .CNT_W    (CW),
        .PRESCALE (PS),
        .BASE_ADDR(8'hF0)
    ) dut (
        .CLK                (clk),
        .RESET_N            (rst_n),
        .BUS_ADDR           (addr),
        .BUS_DATA           (bus_data),
        .BUS_WE             (we),
        .BUS_INTERRUPT_RAISE(raise),
        .BUS_INTERRUPT_ACK  (ack)
    );

    always #5 clk = ~clk;

    // Bench's own prescaler model: edge number since reset release; a tick edge is every PS-th edge
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(input logic [7:0] a, input logic w, input logic [7:0] d);
        vec_t v;
        v.addr = a;
        v.we   = w;
        v.data = d;
        return v;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
        end
    endtask

    // All tasks start and end just after a falling edge
    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        oe    = 1'b1;
        @(negedge clk);
        we    = 1'b0;
        oe    = 1'b0;
        addr  = 8'h00;
    endtask

    task automatic rd_chk(input logic [7:0] a, input logic [7:0] exp, input string name);
        logic [7:0] e;
        sb_q.push_back(exp);
        addr = a;
        we   = 1'b0;
        @(negedge clk);
        addr = 8'h00;
        if (sb_q.size() == 0) begin
            check({name, "_sb_empty"}, 8'h01, 8'h00);
        end else begin
            e = sb_q.pop_front();
            check(name, bus_data, e);
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Stop at the falling edge whose following rising edge has phase r+1 (r = PS-1: the next edge ticks)
    task automatic align(input int unsigned r);
        for (int i = 0; i < int'(PS) && (cyc % PS) != r; i++) @(negedge clk);
    endtask

    task automatic wait_raise(input int max, output int n);
        n = 0;
        while (!raise && n < max) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic pulse_ack();
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
    endtask

    initial begin
        int          n;
        int unsigned t0;
        logic        seen;

        vecs[0]  = mk(8'hF0, 1'b0, 8'h00);  // reset CTRL
        vecs[1]  = mk(8'hF1, 1'b0, 8'h00);
        vecs[2]  = mk(8'hF2, 1'b0, 8'h00);
        vecs[3]  = mk(8'hF8, 1'b0, 8'h00);
        vecs[4]  = mk(8'hF1, 1'b1, 8'h34);
        vecs[5]  = mk(8'hF2, 1'b1, 8'hFF);
        vecs[6]  = mk(8'hF1, 1'b0, 8'h00);  // reload write leaves COUNT alone
        vecs[7]  = mk(8'hF0, 1'b1, 8'h08);  // RESTART with EN=0 loads and freezes
        vecs[8]  = mk(8'hF1, 1'b0, 8'h34);
        vecs[9]  = mk(8'hF2, 1'b0, 8'h0F);  // bits above CNT_W read 0
        vecs[10] = mk(8'hF0, 1'b0, 8'h00);  // RESTART self-clears
        vecs[11] = mk(8'hF4, 1'b1, 8'h06);
        vecs[12] = mk(8'hF4, 1'b0, 8'h06);
        vecs[13] = mk(8'hF3, 1'b0, 8'h00);  // reserved
        vecs[14] = mk(8'hFC, 1'b1, 8'h07);  // beyond NUM_CH: ignored
        vecs[15] = mk(8'h04, 1'b1, 8'h02);  // outside the window: ignored
        vecs[16] = mk(8'hF4, 1'b0, 8'h06);
        vecs[17] = mk(8'hF0, 1'b0, 8'h00);
        vecs[18] = mk(8'hF4, 1'b1, 8'h00);

        repeat (3) @(negedge clk);
        check("reset_raise", 8'(raise), 8'h00);
        rst_n = 1'b1;

        for (int i = 0; i < int'(NV); i++) begin
            if (vecs[i].we) wr(vecs[i].addr, vecs[i].data);
            else            rd_chk(vecs[i].addr, vecs[i].data, $sformatf("vec%0d", i));
        end
        check("idle_raise", 8'(raise), 8'h00);

        // Periodic, RELOAD=3: expiry every 4 ticks = 16 cycles
        wr(8'hF1, 8'h03);
        wr(8'hF2, 8'h00);
        align(PS - 1);
        wr(8'hF0, 8'h07);
        wait_raise(40, n);
        check("periodic_first", 8'(n), 8'd16);
        t0 = cyc;
        pulse_ack();
        check("periodic_ack_fall", 8'(raise), 8'h00);
        rd_chk(8'hF1, 8'h03, "periodic_reload");
        rd_chk(8'hF0, 8'h07, "periodic_ctrl");
        wait_raise(40, n);
        check("periodic_period", 8'(cyc - t0), 8'd16);
        pulse_ack();
        check("periodic_ack2", 8'(raise), 8'h00);
        wr(8'hF0, 8'h80);

        // One-shot on channel 1, RELOAD=2: single expiry 3 ticks after start
        wr(8'hF5, 8'h02);
        wr(8'hF6, 8'h00);
        align(PS - 1);
        wr(8'hF4, 8'h05);
        wait_raise(40, n);
        check("oneshot_time", 8'(n), 8'd12);
        rd_chk(8'hF4, 8'h84, "oneshot_ctrl");
        rd_chk(8'hF5, 8'h00, "oneshot_count");
        pulse_ack();
        check("oneshot_ack", 8'(raise), 8'h00);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (raise) seen = 1'b1;
        end
        check("oneshot_no_rearm", 8'(seen), 8'h00);
        rd_chk(8'hF5, 8'h00, "oneshot_count_held");

        // Priority: channels 0 and 2 expire on the same tick
        wr(8'hF1, 8'h01);
        wr(8'hF9, 8'h01);
        wr(8'hFA, 8'h00);
        align(PS - 1);
        wr(8'hF0, 8'h05);
        wr(8'hF8, 8'h05);
        wait_raise(20, n);
        check("prio_raise", 8'(raise), 8'h01);
        rd_chk(8'hF0, 8'h84, "prio_ch0_pend");
        rd_chk(8'hF8, 8'h84, "prio_ch2_pend");
        pulse_ack();
        check("prio_raise_hold", 8'(raise), 8'h01);
        rd_chk(8'hF0, 8'h04, "prio_ch0_cleared");
        rd_chk(8'hF8, 8'h84, "prio_ch2_still");
        pulse_ack();
        check("prio_raise_fall", 8'(raise), 8'h00);
        rd_chk(8'hF8, 8'h04, "prio_ch2_cleared");

        // Collisions with RELOAD=0 periodic: expiry on every tick
        wr(8'hF1, 8'h00);
        align(PS - 1);
        wr(8'hF0, 8'h07);
        idle(1);
        align(PS - 1);
        pulse_ack();
        check("collision_ack", 8'(raise), 8'h01);
        pulse_ack();
        check("ack_clear", 8'(raise), 8'h00);
        align(PS - 1);
        wr(8'hF0, 8'h83);
        rd_chk(8'hF0, 8'h83, "collision_swclr");
        check("ie0_no_raise", 8'(raise), 8'h00);
        wr(8'hF0, 8'h80);
        rd_chk(8'hF0, 8'h00, "swclr_pend");

        // Wide read across a tick: HI after LO
        wr(8'hF5, 8'h00);
        wr(8'hF6, 8'h01);
        align(PS - 1);
        wr(8'hF4, 8'h01);
        rd_chk(8'hF5, 8'h00, "snap_lo");
        idle(2);
`ifdef TIMER_SNAPSHOT_EN
        rd_chk(8'hF6, 8'h01, "snap_hi");
`else
        rd_chk(8'hF6, 8'h00, "snap_hi");
`endif
        rd_chk(8'hF5, 8'hFF, "snap_lo2");
        rd_chk(8'hF6, 8'h00, "snap_hi2");
        wr(8'hF4, 8'h00);

        // Asynchronous reset mid-count
        wr(8'hF1, 8'h05);
        wr(8'hF0, 8'h07);
        idle(6);
        #2 rst_n = 1'b0;
        #1 check("rst_async_raise", 8'(raise), 8'h00);
        idle(2);
        rst_n = 1'b1;
        rd_chk(8'hF0, 8'h00, "rst_ctrl");
        rd_chk(8'hF1, 8'h00, "rst_count");
        rd_chk(8'hF4, 8'h00, "rst_ctrl1");
        wr(8'hF0, 8'h08);
        rd_chk(8'hF1, 8'h00, "rst_reload");
        idle(8);
        check("rst_raise", 8'(raise), 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
